// File: rtl/shift_chain_pkg.sv
// Shared types and defaults for the serial shift-chain sequencer.
// Holds the FSM state encoding and the counter sizing helper.
package shift_chain_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_CLK_DIV = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_chain_ctrl_if.sv
// Handshake, chain and status signals of the shift-chain sequencer.
// master = the sequencer itself; slave = register logic plus chain around it.
interface shift_chain_ctrl_if
    import shift_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_out;
    logic             ser_in;
    logic             shift_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             abort;
    logic             busy;

    modport master (
        input  in_valid, in_data, ser_in, out_ready, abort,
        output in_ready, ser_out, shift_en, out_valid, out_data, busy
    );

    modport slave (
        output in_valid, in_data, ser_in, out_ready, abort,
        input  in_ready, ser_out, shift_en, out_valid, out_data, busy
    );

endinterface

// File: rtl/shift_chain_ctrl_bit_rate_gen.sv
// Bit-period divider: strobe marks the last clk cycle of each bit period.
// Latency: first strobe CLK_DIV cycles after run rises with the counter cleared.
// Backpressure: none; clr holds the counter at zero, run lets it advance.
module bit_rate_gen
    import shift_chain_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic strobe
);
    localparam int            CW   = cnt_w(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    // Decoded from flops only, so no input reaches the chain's clock enable.
    assign strobe = run && (div_cnt_q == LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr) begin
            div_cnt_d = '0;
        end else if (run) begin
            div_cnt_d = strobe ? '0 : div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/shift_chain_ctrl.sv
// Serialises a parallel word MSB-first into a DFF chain and captures its output.
// Latency: WIDTH*CLK_DIV cycles from accept to out_valid; one IDLE cycle between words.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready or abort.
module shift_chain_ctrl
    import shift_chain_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input logic               clk,
    input logic               rst_n,
    shift_chain_ctrl_if.master bus
);
    localparam int            BW       = cnt_w(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             strobe;

    bit_rate_gen #(.CLK_DIV(CLK_DIV)) u_bit_rate_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q != SHIFT),
        .run    (state_q == SHIFT),
        .strobe (strobe)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    tx_d      = bus.in_data;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Abort drops the partial word so ser_out rests at 0 in IDLE.
                if (bus.abort) begin
                    tx_d      = '0;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else if (strobe) begin
                    tx_d = {tx_q[WIDTH-2:0], 1'b0};
                    rx_d = {rx_q[WIDTH-2:0], bus.ser_in};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.abort || bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = rx_q;
    assign bus.ser_out   = tx_q[WIDTH-1];
    assign bus.shift_en  = strobe;

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Randomised bench for shift_chain_ctrl: one instance at CLK_DIV=1 (loopback or
// an external 16-stage chain) and one at CLK_DIV=4 (loopback), selected by sel.
module tb_shift_chain_ctrl;
    import shift_chain_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         sel = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         abort = 1'b0;
    logic         lb1 = 1'b1;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] chain1 = '0;
    logic         preset_req = 1'b0;
    logic [W-1:0] preset_val = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc[$];
    logic [W-1:0] got_q[$];

    shift_chain_ctrl_if #(.WIDTH(W)) if1 ();
    shift_chain_ctrl_if #(.WIDTH(W)) if4 ();

    shift_chain_ctrl #(.WIDTH(W), .CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    shift_chain_ctrl #(.WIDTH(W), .CLK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    assign if1.in_valid  = in_valid & ~sel;
    assign if1.in_data   = in_data;
    assign if1.out_ready = out_ready & ~sel;
    assign if1.abort     = abort & ~sel;
    assign if1.ser_in    = lb1 ? if1.ser_out : chain1[W-1];
    assign if4.in_valid  = in_valid & sel;
    assign if4.in_data   = in_data;
    assign if4.out_ready = out_ready & sel;
    assign if4.abort     = abort & sel;
    assign if4.ser_in    = if4.ser_out;

    logic         m_in_ready, m_busy, m_shift_en, m_out_valid, m_ser_out;
    logic [W-1:0] m_out_data;
    logic [4:0]   st;
    assign m_in_ready  = sel ? if4.in_ready  : if1.in_ready;
    assign m_busy      = sel ? if4.busy      : if1.busy;
    assign m_shift_en  = sel ? if4.shift_en  : if1.shift_en;
    assign m_out_valid = sel ? if4.out_valid : if1.out_valid;
    assign m_ser_out   = sel ? if4.ser_out   : if1.ser_out;
    assign m_out_data  = sel ? if4.out_data  : if1.out_data;
    assign st = {m_in_ready, m_busy, m_shift_en, m_out_valid, m_ser_out};

    // Environment: the external chain, accept/result logging, cycle count.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preset_req) chain1 <= preset_val;
        else if (if1.shift_en) chain1 <= {chain1[W-2:0], if1.ser_out};
        if (in_valid && m_in_ready) acc_cyc.push_back(cyc);
        if (m_out_valid && out_ready) got_q.push_back(m_out_data);
    end

    // One transfer on instance s; status vector is {in_ready,busy,shift_en,out_valid,ser_out}.
    task automatic do_xfer(input int s, input logic [W-1:0] w, input logic [W-1:0] exp_o,
                           input int hold, input int abort_after);
        int d;
        logic [4:0] e;
        d = s ? 4 : 1;
        sel = s[0];
        @(negedge clk);
        n_cmp++;
        if (st !== 5'b10000) begin
            n_bad++; $display("FAIL idle_before got %b want %b", st, 5'b10000);
        end
        in_valid = 1'b1; in_data = w;
        for (int j = 1; j <= W * d; j++) begin
            @(negedge clk);
            e = {1'b0, 1'b1, (j % d == 0), 1'b0, w[W-1-(j-1)/d]};
            n_cmp++;
            if (st !== e) begin
                n_bad++; $display("FAIL shift_cycle s=%0d j=%0d got %b want %b", s, j, st, e);
            end
            in_valid = 1'($urandom_range(0, 1)); in_data = W'($urandom);
            if (abort_after > 0 && j == abort_after * d + 1) begin
                abort = 1'b1; in_valid = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                n_cmp++;
                if (st !== 5'b10000) begin
                    n_bad++; $display("FAIL abort_idle got %b want %b", st, 5'b10000);
                end
                for (int k = 0; k < 3 * d; k++) begin
                    @(negedge clk);
                    n_cmp++;
                    if ({m_shift_en, m_out_valid} !== 2'b00) begin
                        n_bad++; $display("FAIL abort_quiet k=%0d got %b want 00", k, {m_shift_en, m_out_valid});
                    end
                end
                return;
            end
        end
        for (int k = 0; k <= hold; k++) begin
            @(negedge clk);
            n_cmp++;
            if (st !== 5'b01010 || m_out_data !== exp_o) begin
                n_bad++;
                $display("FAIL done_hold k=%0d got %b/%h want %b/%h", k, st, m_out_data, 5'b01010, exp_o);
            end
            if (k == hold) begin
                out_ready = 1'b1; in_valid = 1'b0;
            end else begin
                out_ready = 1'b0;
                in_valid = 1'($urandom_range(0, 1)); in_data = W'($urandom);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (st !== 5'b10000) begin
            n_bad++; $display("FAIL idle_after got %b want %b", st, 5'b10000);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            n_cmp++;
            if (st !== 5'b10000 || m_out_data !== '0) begin
                n_bad++; $display("FAIL reset_state s=%0d got %b/%h want 10000/0000", s, st, m_out_data);
            end
        end
    endtask

    task automatic test_loopback();
        lb1 = 1'b1;
        do_xfer(0, 16'hA5C3, 16'hA5C3, 0, 0);
    endtask

    task automatic test_div4();
        do_xfer(1, 16'h8001, 16'h8001, 0, 0);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w;
        w = W'($urandom);
        do_xfer(0, w, w, 10, 0);
        w = W'($urandom);
        do_xfer(1, w, w, 10, 0);
    endtask

    task automatic test_abort();
        lb1 = 1'b1;
        do_xfer(0, W'($urandom), '0, 0, 7);
        do_xfer(0, 16'h1234, 16'h1234, 0, 0);
        do_xfer(1, W'($urandom), '0, 0, 7);
        do_xfer(1, 16'h1234, 16'h1234, 0, 0);
    endtask

    // Through a full-length chain, the result is the chain's previous contents.
    task automatic test_chain();
        logic [W-1:0] p, w;
        for (int i = 0; i < 4; i++) begin
            p = W'($urandom); w = W'($urandom);
            sel = 1'b0;
            @(negedge clk); preset_val = p; preset_req = 1'b1;
            @(negedge clk); preset_req = 1'b0;
            lb1 = 1'b0;
            do_xfer(0, w, p, $urandom_range(0, 2), 0);
            n_cmp++;
            if (chain1 !== w) begin
                n_bad++; $display("FAIL chain_contents got %h want %h", chain1, w);
            end
        end
        lb1 = 1'b1;
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        int s;
        for (int i = 0; i < 6; i++) begin
            s = $urandom_range(0, 1); w = W'($urandom);
            do_xfer(s, w, w, $urandom_range(0, 3), 0);
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] w;
        sel = 1'b1;
        @(negedge clk); in_valid = 1'b1; in_data = W'($urandom);
        @(negedge clk); in_valid = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (m_busy !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_busy got %b want 1", m_busy);
        end
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (st !== 5'b10000 || m_out_data !== '0) begin
            n_bad++; $display("FAIL async_reset got %b/%h want 10000/0000", st, m_out_data);
        end
        @(negedge clk); rst_n = 1'b1;
        w = W'($urandom);
        do_xfer(1, w, w, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        int ba, bg, t;
        a = W'($urandom); b = ~a;
        lb1 = 1'b1; sel = 1'b0;
        ba = acc_cyc.size(); bg = got_q.size();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_data = a;
        t = 0;
        while (got_q.size() < bg + 2 && t < 100) begin
            @(negedge clk);
            t++;
            if (acc_cyc.size() == ba + 1) in_data = b;
            if (acc_cyc.size() >= ba + 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got_q.size() < bg + 2 || acc_cyc.size() < ba + 2) begin
            n_bad++; $display("FAIL b2b_timeout got %0d results want 2", got_q.size() - bg);
        end else begin
            n_cmp++;
            if (got_q[bg] !== a || got_q[bg+1] !== b) begin
                n_bad++; $display("FAIL b2b_order got %h,%h want %h,%h", got_q[bg], got_q[bg+1], a, b);
            end
            n_cmp++;
            if (acc_cyc[ba+1] - acc_cyc[ba] != W + 2) begin
                n_bad++; $display("FAIL b2b_gap got %0d want %0d", acc_cyc[ba+1] - acc_cyc[ba], W + 2);
            end
        end
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (acc_cyc.size() != ba + 2 || st !== 5'b10000) begin
            n_bad++; $display("FAIL b2b_settle got %0d accepts/%b want 2/10000", acc_cyc.size() - ba, st);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_loopback();
        test_div4();
        test_backpressure();
        test_abort();
        test_chain();
        test_random();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d want completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_chain_ctrl.md
# shift_chain_ctrl

Sequencer for the serial DFF shift chains in this design (the 16-bit shift register and its variants). It accepts a parallel word over a valid/ready handshake and drives it MSB-first into the chain input at a programmable bit rate, issuing one shift strobe per bit. It captures the chain's serial output into a parallel result, which it presents over a second valid/ready handshake. It sits between the register-level logic and the chain. It is the only block allowed to assert the chain's shift strobe.

## Interface
- WIDTH, 16, bits per transfer; equals chain length; ≥2
- CLK_DIV, 1, clk cycles per bit period; ≥1
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  parallel word available
- in_ready  out  1  controller idle and able to accept a word
- in_data  in  WIDTH  word to shift out; bit WIDTH-1 goes first
- ser_out  out  1  drives the chain's data_in
- ser_in  in  1  sampled from the chain's data_out
- shift_en  out  1  one-cycle strobe; gates the chain's clock enable
- out_valid  out  1  captured word valid
- out_ready  in  1  consumer accepts the captured word
- out_data  out  WIDTH  captured word; first bit sampled lands in bit WIDTH-1
- abort  in  1  synchronous cancel of the current transfer
- busy  out  1  high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&in_ready: load tx_reg←in_data, clear bit_cnt and div_cnt, go to SHIFT.
- SHIFT
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - shift_en=1 exactly in the cycle where div_cnt==CLK_DIV-1.
  - ser_out=tx_reg[WIDTH-1] for the whole bit period.
  - On each strobe edge:
    - tx_reg shifts left with 0 fill.
    - rx_reg←{rx_reg[WIDTH-2:0], ser_in}.
    - bit_cnt increments.
  - On the strobe with bit_cnt==WIDTH-1: go to DONE.
- DONE
  - out_valid=1; out_data=rx_reg, held stable.
  - On out_valid&out_ready: go to IDLE.
- abort
  - In SHIFT or DONE: go to IDLE next edge; out_valid never rises; no further shift_en.
  - In IDLE: ignored.
  - abort wins over a simultaneous strobe or out handshake.
- in_valid outside IDLE is ignored; in_data is not sampled.
- Counters are sized $clog2(WIDTH) and $clog2(CLK_DIV) (minimum 1 bit). bit_cnt never exceeds WIDTH-1.
- Reset values: state=IDLE, tx_reg=0, rx_reg=0, counters=0.
  - Outputs under reset: in_ready=1, ser_out=0, shift_en=0, out_valid=0, out_data=0, busy=0.
- Reset asserted mid-transfer: all of the above take effect immediately (asynchronous); the partial word is discarded.
- All outputs are decoded from registers. No combinational path from any input to any output.

## Timing
- Accept at edge T0.
- Strobes fall in the cycles ending at edges T0+k·CLK_DIV, for k=1..WIDTH.
- out_valid is high from T0+WIDTH·CLK_DIV until the handshake edge.
- After the out handshake, in_ready=1 the next cycle. Minimum transfer-to-transfer gap is 1 cycle in IDLE.
- Loopback (ser_out→ser_in, no chain delay) returns in_data unchanged.
- With an N-stage chain, out_data holds the chain contents shifted by WIDTH positions.

## Structure
- Package shift_chain_pkg holds:
  - the state enum typedef (IDLE, SHIFT, DONE);
  - default WIDTH and CLK_DIV localparams.
- One sub-module, bit_rate_gen: the div_cnt counter, with inputs clr and run and output strobe.
- The FSM and the datapath stay in shift_chain_ctrl.

## Test plan
- WIDTH=16, CLK_DIV=1, loopback, send 0xA5C3 → exactly 16 shift_en pulses on consecutive cycles; out_valid rises 16 cycles after accept; out_data=0xA5C3.
- CLK_DIV=4, send 0x8001 → shift_en on every 4th cycle; ser_out=1 for the first 4 and last 4 cycles, 0 in between; out_valid at accept+64.
- Hold out_ready=0 for 10 cycles in DONE → out_valid stays 1; out_data stable; in_ready=0; in_valid pulses ignored.
- Pulse abort after the 7th strobe → IDLE next cycle; no further shift_en; out_valid stays 0; next word 0x1234 completes correctly.
- Pulse rst_n low mid-SHIFT → all outputs go to their reset values asynchronously; after release, in_ready=1 and a new transfer completes normally.
- Back-to-back transfers with out_ready tied 1 and in_valid held → 1 idle cycle between transfers; two distinct words return in order.
